// File: rtl/apb_wait_ram.sv
// apb_wait_ram
// APB slave scratch RAM with byte-lane strobes, programmable wait states and
// error responses for misaligned, out-of-range and protection-violating
// accesses.
//
// Ports:
//   clk, rst      bus clock, asynchronous active-high reset
//   sel, enable   PSEL / PENABLE
//   write         1 = write, 0 = read
//   addr          byte address (ADDR_WIDTH)
//   wdata, strb   write data and byte-lane strobes
//   prot          PPROT; prot[0] = privileged
//   rdata         read data, nonzero only on a successful completing read
//   ready         PREADY
//   slverr        PSLVERR, only ever high together with ready
module apb_wait_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int PROT_CHECK  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sel,
    input  logic                    enable,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] strb,
    input  logic [2:0]              prot,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    ready,
    output logic                    slverr
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFS = $clog2(NB);
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } phase_e;

    // The bus phase is fully determined by sel/enable in the current cycle,
    // so it is decoded rather than registered; that is what lets a zero-wait
    // access complete in its first access cycle. The only state carried
    // across cycles is the wait counter.
    phase_e phase;
    logic [3:0] cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] idx;
    logic [IW-1:0]         ix;
    logic                  mis, oor, perr, err;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // prot[2:1] carry no meaning for this slave
    logic unused_prot;
    assign unused_prot = ^prot[2:1];

    always_comb begin
        phase = IDLE;
        if (sel && enable)
            phase = ACCESS;
        else if (sel)
            phase = SETUP;
    end

    // Gated with rst so ready/slverr drop the moment reset is asserted,
    // not only once the counter has been cleared.
    assign ready = !rst && (phase == ACCESS) && (cnt_q == 4'(WAIT_STATES));

    // Counter runs only while in ACCESS and not yet done; a completion,
    // an abort (sel low) or a return to SETUP all start the next transfer
    // from zero.
    always_comb begin
        cnt_d = '0;
        if (phase == ACCESS && !ready)
            cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Address decode and error classification
    assign idx  = addr >> OFFS;
    assign ix   = idx[IW-1:0];
    assign mis  = (addr & ADDR_WIDTH'((1 << OFFS) - 1)) != '0;
    assign oor  = {1'b0, idx} >= (ADDR_WIDTH+1)'(DEPTH);
    assign perr = (PROT_CHECK != 0) && write && !prot[0];
    assign err  = mis || oor || perr;

    assign slverr = ready && err;
    assign rdata  = (ready && !write && !err) ? mem[ix] : '0;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (ready && write && !err) begin
            for (int i = 0; i < NB; i++) begin
                if (strb[i])
                    mem[ix][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

endmodule
